// File: rtl/fun_batch.sv
// Batches operand pairs through an external fun engine (a*floor(cbrt(b))) and
// reports the sum and count of the results once per batch.
module fun_batch #(
  parameter int MAX_BATCH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_last,
  output logic        in_ready,
  output logic        fun_start,
  output logic [7:0]  fun_a,
  output logic [7:0]  fun_b,
  input  logic        fun_busy,
  input  logic [10:0] fun_result,
  output logic        out_valid,
  output logic [17:0] out_sum,
  output logic [7:0]  out_count,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OUT
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BATCH);

  state_t      state, state_nxt;
  logic        last_q;
  logic [17:0] acc;
  logic [7:0]  count;
  logic [7:0]  count_inc;
  logic        accept;
  logic        capture;
  logic        drain;

  assign count_inc = count + 8'd1;
  assign accept    = in_valid && (state == IDLE);
  assign capture   = (state == WAIT_DONE) && !fun_busy;
  assign drain     = (state == OUT) && out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    fun_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        fun_start = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (fun_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // A batch closes on the registered last flag or on reaching the size cap.
        if (!fun_busy) state_nxt = (last_q || count_inc == MAX_CNT) ? OUT : IDLE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fun_a  <= '0;
      fun_b  <= '0;
      last_q <= 1'b0;
      acc    <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        fun_a  <= in_a;
        fun_b  <= in_b;
        last_q <= in_last;
      end
      if (capture) begin
        acc   <= acc + {7'd0, fun_result};
        count <= count_inc;
      end else if (drain) begin
        acc   <= '0;
        count <= '0;
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = count;

endmodule

// File: tb/tb_fun_batch.sv
// Directed bench for fun_batch with a behavioural fun engine whose busy
// start delay and busy length can be varied per test.
module tb_fun_batch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        in_ready;
  logic        fun_start;
  logic [7:0]  fun_a;
  logic [7:0]  fun_b;
  logic        fun_busy;
  logic [10:0] fun_result;
  logic        out_valid;
  logic [17:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ready;

  int total = 0;
  int bad = 0;
  int start_cycles = 0;
  int rise_gap = 0;
  int eng_lat = 2;
  logic [7:0] exp_a = 8'd0;
  logic [7:0] exp_b = 8'd0;

  always #5 clk = ~clk;

  fun_batch #(.MAX_BATCH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .in_ready(in_ready),
    .fun_start(fun_start), .fun_a(fun_a), .fun_b(fun_b),
    .fun_busy(fun_busy), .fun_result(fun_result),
    .out_valid(out_valid), .out_sum(out_sum), .out_count(out_count),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int cbrt(input int b);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  // Fun engine model; its reset follows rst_n.
  initial begin : engine
    logic [7:0] a_l;
    logic [7:0] b_l;
    fun_busy   = 1'b0;
    fun_result = 11'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fun_busy = 1'b0;
      end else if (fun_start) begin
        check("fun_a_at_start", fun_a, exp_a);
        check("fun_b_at_start", fun_b, exp_b);
        a_l = fun_a;
        b_l = fun_b;
        repeat (rise_gap + 1) @(negedge clk);
        fun_busy   = 1'b1;
        fun_result = 11'h7FF;
        for (int i = 0; i < eng_lat && rst_n; i++) @(negedge clk);
        fun_result = 11'(int'(a_l) * cbrt(int'(b_l)));
        fun_busy   = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (fun_start) start_cycles++;
      if (fun_busy && rst_n) check("in_ready_while_busy", in_ready, 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Starts and ends on a falling edge.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    exp_a    = a;
    exp_b    = b;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = 8'hA5;
    in_b     = 8'h5A;
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic collect(input string tag, input int sum, input int cnt, input int hold);
    int n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_in_ready_out"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_sum"}, out_sum, sum);
      check({tag, "_hold_count"}, out_count, cnt);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained_valid"}, out_valid, 0);
    check({tag, "_drained_in_ready"}, in_ready, 1);
    check({tag, "_cleared_sum"}, out_sum, 0);
    check({tag, "_cleared_count"}, out_count, 0);
  endtask

  initial begin : main
    int n;
    bit saw_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_fun_start", fun_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_fun_a", fun_a, 0);
    check("rst_fun_b", fun_b, 0);

    // Single pair: 3*cbrt(8) = 6
    send_pair(8'd3, 8'd8, 1'b1);
    collect("single", 6, 1, 0);
    check("single_start_cycles", start_cycles, 1);

    // Three pairs with a slow engine: 6 + 15 + 1530, then 5 back-pressure cycles
    rise_gap = 2;
    eng_lat  = 3;
    send_pair(8'd3, 8'd8, 1'b0);
    send_pair(8'd5, 8'd27, 1'b0);
    send_pair(8'd255, 8'd255, 1'b1);
    collect("three", 1551, 3, 5);
    check("three_start_cycles", start_cycles, 4);

    // Full batch at the size cap: 128 * 1530
    rise_gap = 0;
    eng_lat  = 1;
    for (int i = 0; i < 128; i++) send_pair(8'd255, 8'd255, 1'b0);
    collect("full", 195840, 128, 0);
    send_pair(8'd3, 8'd8, 1'b1);
    collect("after_full", 6, 1, 0);

    // b = 0 gives a zero result but still counts
    send_pair(8'd200, 8'd0, 1'b1);
    collect("zero_b", 0, 1, 0);

    // Reset while the second pair is in WAIT_DONE
    eng_lat = 6;
    send_pair(8'd1, 8'd1, 1'b0);
    send_pair(8'd4, 8'd8, 1'b0);
    n = 0;
    while (!fun_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_busy_seen", fun_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_count", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_no_out_valid", saw_valid, 0);
    eng_lat = 2;
    send_pair(8'd2, 8'd64, 1'b1);
    collect("fresh", 8, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
